alu_rr_sequencer: RTL and testbench
===================================

Name: alu_rr_sequencer

Overview:
- Parametrised control sequencer for register-register ALU instructions on the bus datapath.
- Replaces hand-sequenced control steps: runs fetch (T0–T2) and execute (T3–T5) and drives every enable/select line of the datapath.
- Decodes opcode and register fields from IR_Data.
- Adds a memory wait-state handshake, back-to-back execution, illegal-instruction detection and register-count generalisation.

Parameters:
- DATA_W, 32, datapath/IR width.
- REG_COUNT, 16, number of general registers (one-hot enable/select width).
- REG_SEL_W, 4, width of each IR register field; REG_COUNT <= 2**REG_SEL_W.
- OPC_W, 5, opcode width; DATA_W >= OPC_W+3*REG_SEL_W.
- ALU_OPC_MIN, 3, lowest legal ALU reg-reg opcode.
- ALU_OPC_MAX, 11, highest legal ALU reg-reg opcode (ROL = 01011).

Ports:
- clk  in  1  rising-edge clock
- clear  in  1  asynchronous active-high reset
- start  in  1  request an instruction; sampled in IDLE and T5
- mem_ready  in  1  memory read data valid
- IR_Data  in  DATA_W  instruction register contents
- PC_select, PC_enable, PC_increment_enable  out  1  PC bus drive / load / increment
- MAR_enable, MDR_enable, MDR_select, read  out  1  memory interface controls
- IR_enable, Y_enable, Z_enable, Z_LO_select, Z_HI_select  out  1  IR / Y / Z controls
- reg_select  out  REG_COUNT  one-hot register bus drive
- reg_enable  out  REG_COUNT  one-hot register load
- lo_enable, hi_enable  out  1  LO/HI load (feature only)
- alu_instruction  out  OPC_W  ALU opcode
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on instruction retire
- illegal  out  1  one-cycle pulse on illegal decode

Behaviour:
- All outputs are registered and decoded from the state register.
- While clear is high, or after reset: state IDLE, all outputs 0.
- Clear mid-instruction aborts immediately; no partial write beyond that already clocked.
- State transitions:
  - IDLE: start=1 -> T0 next edge.
  - T0: PC_select, MAR_enable, PC_increment_enable, Z_enable. -> T1.
  - T1: Z_LO_select, PC_enable, read, MDR_enable. Hold in T1 while mem_ready=0 (wait state; PC_enable pulses only on the first T1 cycle). -> T2 when mem_ready=1.
  - T2: MDR_select, IR_enable. -> T3.
  - T3: capture opcode = IR_Data[DATA_W-1 -: OPC_W], Ra/Rb/Rc in the next three REG_SEL_W fields (MSB first). If legal: reg_select[Rb], Y_enable, -> T4. If illegal: no outputs asserted, illegal pulse next cycle, -> IDLE.
  - T4: reg_select[Rc], alu_instruction = opcode, Z_enable. -> T5.
  - T5: Z_LO_select, reg_enable[Ra], done=1. Then start=1 -> T0 (back-to-back, no IDLE cycle); else -> IDLE.
- An instruction is illegal if opcode is outside [ALU_OPC_MIN, ALU_OPC_MAX], or any used register index >= REG_COUNT.
- alu_instruction is 0 outside T4.
- Ra = Rb = Rc is legal.
- start is ignored in T0–T4.
- Fetch latency with mem_ready tied high: 6 cycles start-to-done.

Optional Feature:
- Macro: SEQ_MULDIV_EN.
- Defined:
  - Opcodes 01111 (MUL) and 10000 (DIV) are legal; fields Ra and Rb are used and Rc is ignored.
  - T3 selects Ra; T4 selects Rb with the opcode.
  - T5 asserts Z_LO_select and lo_enable, then a T6 state asserts Z_HI_select, hi_enable and done.
  - Latency is 7 cycles.
- Undefined:
  - MUL/DIV are illegal.
  - lo_enable, hi_enable and Z_HI_select are constant 0.
  - No T6 state.

Test Plan:
- IR_Data=0x589A8000, start pulse, mem_ready=1 -> T3 reg_select=bit3, T4 reg_select=bit5 with alu_instruction=01011, T5 reg_enable=bit1, done at cycle 6, then IDLE.
- Same instruction with mem_ready low for 3 cycles in T1 -> read/MDR_enable held 4 cycles, PC_enable for 1 cycle only, done at cycle 9.
- start held high for 2 instructions -> T5 goes straight to T0; exactly two done pulses, 6 cycles apart.
- IR_Data=0xF8000000 (opcode 11111) -> illegal pulse after T3, no reg_enable/Y_enable/Z_enable in execute, busy drops.
- clear asserted during T4 -> all outputs 0 asynchronously; next start runs a full clean sequence from T0.
- SEQ_MULDIV_EN, IR_Data opcode 01111, Ra=2, Rb=4 -> lo_enable in T5, hi_enable with Z_HI_select in T6, done at cycle 7; without the macro the same IR gives an illegal pulse.

Source files
------------

// File: rtl/alu_rr_sequencer.sv
// Register-register ALU instruction sequencer: fetch T0-T2, execute T3-T5, registered controls.
// Optional macro SEQ_MULDIV_EN adds MUL/DIV (opcodes 01111/10000) with a T6 state writing LO/HI.
module alu_rr_sequencer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_COUNT   = 16,
    parameter int unsigned REG_SEL_W   = 4,
    parameter int unsigned OPC_W       = 5,
    parameter int unsigned ALU_OPC_MIN = 3,
    parameter int unsigned ALU_OPC_MAX = 11
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 mem_ready,
    input  logic [DATA_W-1:0]    IR_Data,
    output logic                 PC_select,
    output logic                 PC_enable,
    output logic                 PC_increment_enable,
    output logic                 MAR_enable,
    output logic                 MDR_enable,
    output logic                 MDR_select,
    output logic                 read,
    output logic                 IR_enable,
    output logic                 Y_enable,
    output logic                 Z_enable,
    output logic                 Z_LO_select,
    output logic                 Z_HI_select,
    output logic [REG_COUNT-1:0] reg_select,
    output logic [REG_COUNT-1:0] reg_enable,
    output logic                 lo_enable,
    output logic                 hi_enable,
    output logic [OPC_W-1:0]     alu_instruction,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StT0   = 3'd1;
    localparam logic [2:0] StT1   = 3'd2;
    localparam logic [2:0] StT2   = 3'd3;
    localparam logic [2:0] StT3   = 3'd4;
    localparam logic [2:0] StT4   = 3'd5;
    localparam logic [2:0] StT5   = 3'd6;
`ifdef SEQ_MULDIV_EN
    localparam logic [2:0] StT6   = 3'd7;
`endif

    typedef struct packed {
        logic pc_select, pc_enable, pc_inc, mar_en, mdr_en, mdr_sel, read, ir_en;
        logic y_en, z_en, z_lo, z_hi, lo_en, hi_en, busy, done, illegal;
        logic [REG_COUNT-1:0] reg_sel, reg_en;
        logic [OPC_W-1:0]     alu;
    } ctrl_t;

    logic [2:0]           state_q, state_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic [OPC_W-1:0]     opc_q, opc_w;
    logic [REG_SEL_W-1:0] ra_q, rb_q, rc_q, ra_w, rb_w, rc_w;
    logic                 legal_q, md_q, alu_ok, md_ok, legal_w;

    function automatic logic reg_ok(input logic [REG_SEL_W-1:0] r);
        return 32'(r) < REG_COUNT;
    endfunction

    function automatic logic [REG_COUNT-1:0] onehot(input logic [REG_SEL_W-1:0] r);
        logic [REG_COUNT-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) oh[i] = (32'(r) == i);
        return oh;
    endfunction

    // Fields decoded from the IR while in T2 and held for the whole execute phase.
    assign opc_w = IR_Data[DATA_W-1 -: OPC_W];
    assign ra_w  = IR_Data[DATA_W-OPC_W-1 -: REG_SEL_W];
    assign rb_w  = IR_Data[DATA_W-OPC_W-REG_SEL_W-1 -: REG_SEL_W];
    assign rc_w  = IR_Data[DATA_W-OPC_W-2*REG_SEL_W-1 -: REG_SEL_W];

    assign alu_ok = (32'(opc_w) >= ALU_OPC_MIN) && (32'(opc_w) <= ALU_OPC_MAX)
                    && reg_ok(ra_w) && reg_ok(rb_w) && reg_ok(rc_w);
`ifdef SEQ_MULDIV_EN
    assign md_ok  = ((32'(opc_w) == 32'd15) || (32'(opc_w) == 32'd16))
                    && reg_ok(ra_w) && reg_ok(rb_w);
`else
    assign md_ok  = 1'b0;
`endif
    assign legal_w = alu_ok | md_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   if (mem_ready) state_d = StT2;
            StT2:   state_d = StT3;
            StT3:   state_d = legal_q ? StT4 : StIdle;
            StT4:   state_d = StT5;
            StT5: begin
                state_d = start ? StT0 : StIdle;
`ifdef SEQ_MULDIV_EN
                if (md_q) state_d = StT6;
`endif
            end
`ifdef SEQ_MULDIV_EN
            StT6:   state_d = start ? StT0 : StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    // Controls are decoded from the next state so each output flop lines up with its state.
    always_comb begin
        ctrl_d         = '0;
        ctrl_d.busy    = (state_d != StIdle);
        ctrl_d.illegal = (state_q == StT3) && !legal_q;
        case (state_d)
            StT0: begin
                ctrl_d.pc_select = 1'b1;
                ctrl_d.mar_en    = 1'b1;
                ctrl_d.pc_inc    = 1'b1;
                ctrl_d.z_en      = 1'b1;
            end
            StT1: begin
                ctrl_d.z_lo      = 1'b1;
                ctrl_d.read      = 1'b1;
                ctrl_d.mdr_en    = 1'b1;
                ctrl_d.pc_enable = (state_q == StT0);
            end
            StT2: begin
                ctrl_d.mdr_sel = 1'b1;
                ctrl_d.ir_en   = 1'b1;
            end
            StT3: if (legal_w) begin
                ctrl_d.y_en    = 1'b1;
                ctrl_d.reg_sel = onehot(md_ok ? ra_w : rb_w);
            end
            StT4: begin
                ctrl_d.reg_sel = onehot(md_q ? rb_q : rc_q);
                ctrl_d.alu     = opc_q;
                ctrl_d.z_en    = 1'b1;
            end
            StT5: begin
                ctrl_d.z_lo = 1'b1;
                if (md_q) begin
                    ctrl_d.lo_en = 1'b1;
                end else begin
                    ctrl_d.reg_en = onehot(ra_q);
                    ctrl_d.done   = 1'b1;
                end
            end
`ifdef SEQ_MULDIV_EN
            StT6: begin
                ctrl_d.z_hi  = 1'b1;
                ctrl_d.hi_en = 1'b1;
                ctrl_d.done  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
            ctrl_q  <= '0;
            opc_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            legal_q <= 1'b0;
            md_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            if (state_q == StT2) begin
                opc_q   <= opc_w;
                ra_q    <= ra_w;
                rb_q    <= rb_w;
                rc_q    <= rc_w;
                legal_q <= legal_w;
                md_q    <= md_ok;
            end
        end
    end

    assign PC_select           = ctrl_q.pc_select;
    assign PC_enable           = ctrl_q.pc_enable;
    assign PC_increment_enable = ctrl_q.pc_inc;
    assign MAR_enable          = ctrl_q.mar_en;
    assign MDR_enable          = ctrl_q.mdr_en;
    assign MDR_select          = ctrl_q.mdr_sel;
    assign read                = ctrl_q.read;
    assign IR_enable           = ctrl_q.ir_en;
    assign Y_enable            = ctrl_q.y_en;
    assign Z_enable            = ctrl_q.z_en;
    assign Z_LO_select         = ctrl_q.z_lo;
    assign Z_HI_select         = ctrl_q.z_hi;
    assign reg_select          = ctrl_q.reg_sel;
    assign reg_enable          = ctrl_q.reg_en;
    assign lo_enable           = ctrl_q.lo_en;
    assign hi_enable           = ctrl_q.hi_en;
    assign alu_instruction     = ctrl_q.alu;
    assign busy                = ctrl_q.busy;
    assign done                = ctrl_q.done;
    assign illegal             = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Bench for alu_rr_sequencer: directed cases then random instructions, each cycle checked
// against per-phase expectations built from the instruction's decoded fields.
module tb_alu_rr_sequencer;

    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 16;
    localparam int OPC_W     = 5;
    localparam int ALU_MIN   = 3;
    localparam int ALU_MAX   = 11;

    logic                 clk = 1'b0;
    logic                 clear, start, mem_ready;
    logic [DATA_W-1:0]    IR_Data;
    logic                 PC_select, PC_enable, PC_increment_enable, MAR_enable, MDR_enable;
    logic                 MDR_select, read, IR_enable, Y_enable, Z_enable, Z_LO_select;
    logic                 Z_HI_select, lo_enable, hi_enable, busy, done, illegal;
    logic [REG_COUNT-1:0] reg_select, reg_enable;
    logic [OPC_W-1:0]     alu_instruction;

    alu_rr_sequencer dut (
        .clk(clk), .clear(clear), .start(start), .mem_ready(mem_ready), .IR_Data(IR_Data),
        .PC_select(PC_select), .PC_enable(PC_enable),
        .PC_increment_enable(PC_increment_enable), .MAR_enable(MAR_enable),
        .MDR_enable(MDR_enable), .MDR_select(MDR_select), .read(read), .IR_enable(IR_enable),
        .Y_enable(Y_enable), .Z_enable(Z_enable), .Z_LO_select(Z_LO_select),
        .Z_HI_select(Z_HI_select), .reg_select(reg_select), .reg_enable(reg_enable),
        .lo_enable(lo_enable), .hi_enable(hi_enable), .alu_instruction(alu_instruction),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] pad;
        logic pc_sel, pc_en, pc_inc, mar_en, mdr_en, mdr_sel, rd, ir_en, y_en, z_en, z_lo, z_hi;
        logic [REG_COUNT-1:0] rsel, ren;
        logic lo_en, hi_en;
        logic [OPC_W-1:0] alu;
        logic busy, done, illegal;
    } outs_t;

    int n_vec = 0, n_err = 0, cyc = 0, n_inst = 0, n_ret = 0, n_done = 0, done_cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic outs_t obs();
        outs_t o;
        o = '0;
        o.pc_sel = PC_select;  o.pc_en = PC_enable;    o.pc_inc = PC_increment_enable;
        o.mar_en = MAR_enable; o.mdr_en = MDR_enable;  o.mdr_sel = MDR_select;
        o.rd = read;           o.ir_en = IR_enable;    o.y_en = Y_enable;
        o.z_en = Z_enable;     o.z_lo = Z_LO_select;   o.z_hi = Z_HI_select;
        o.rsel = reg_select;   o.ren = reg_enable;     o.lo_en = lo_enable;
        o.hi_en = hi_enable;   o.alu = alu_instruction;
        o.busy = busy;         o.done = done;          o.illegal = illegal;
        return o;
    endfunction

    always @(negedge clk) if (done) begin
        done_cyc = cyc;
        n_done++;
    end

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Runs one instruction; the caller has already arranged for the next edge to enter T0.
    task automatic run_instr(input logic [31:0] ir, input int waits, input bit next_start,
                             input bit abort_t4);
        int opc, ra, rb, rc, t_start;
        bit is_alu, is_md;
        outs_t e;
        opc = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
        is_alu = opc >= ALU_MIN && opc <= ALU_MAX
                 && ra < REG_COUNT && rb < REG_COUNT && rc < REG_COUNT;
        is_md = 1'b0;
`ifdef SEQ_MULDIV_EN
        is_md = (opc == 15 || opc == 16) && ra < REG_COUNT && rb < REG_COUNT;
`endif
        n_inst++;
        IR_Data = ir;
        t_start = cyc;
        tick();
        start = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        e = '0; e.busy = 1; e.pc_sel = 1; e.mar_en = 1; e.pc_inc = 1; e.z_en = 1;
        check_eq($sformatf("T0 i%0d", n_inst), obs(), e);
        for (int k = 0; k <= waits; k++) begin
            tick();
            mem_ready = (k == waits);
            start = 1'($urandom_range(0, 1));
            e = '0; e.busy = 1; e.z_lo = 1; e.rd = 1; e.mdr_en = 1; e.pc_en = (k == 0);
            check_eq($sformatf("T1.%0d i%0d", k, n_inst), obs(), e);
        end
        tick();
        start = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        e = '0; e.busy = 1; e.mdr_sel = 1; e.ir_en = 1;
        check_eq($sformatf("T2 i%0d", n_inst), obs(), e);
        tick();
        e = '0; e.busy = 1;
        if (is_alu || is_md) begin
            e.y_en = 1;
            e.rsel[is_md ? ra : rb] = 1'b1;
        end
        check_eq($sformatf("T3 i%0d", n_inst), obs(), e);
        if (!(is_alu || is_md)) begin
            tick();
            e = '0; e.illegal = 1;
            check_eq($sformatf("illegal i%0d", n_inst), obs(), e);
            return;
        end
        tick();
        e = '0; e.busy = 1; e.z_en = 1; e.alu = OPC_W'(opc);
        e.rsel[is_md ? rb : rc] = 1'b1;
        check_eq($sformatf("T4 i%0d", n_inst), obs(), e);
        if (abort_t4) begin
            #2 clear = 1'b1;
            #1 check_eq("clear mid-T4", obs(), 64'd0);
            @(negedge clk);
            clear = 1'b0;
            return;
        end
        tick();
        e = '0; e.busy = 1; e.z_lo = 1;
        if (is_md) e.lo_en = 1;
        else begin
            e.ren[ra] = 1'b1;
            e.done = 1;
        end
        check_eq($sformatf("T5 i%0d", n_inst), obs(), e);
        if (is_md) begin
            tick();
            e = '0; e.busy = 1; e.z_hi = 1; e.hi_en = 1; e.done = 1;
            check_eq($sformatf("T6 i%0d", n_inst), obs(), e);
        end
        n_ret++;
        @(negedge clk);
        #1;
        check_eq($sformatf("latency i%0d", n_inst), 64'(done_cyc - t_start),
                 64'((is_md ? 7 : 6) + waits));
        start = next_start;
        if (!next_start) begin
            tick();
            check_eq($sformatf("idle i%0d", n_inst), obs(), 64'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d1, waits;
        logic [31:0] r;
        logic [4:0] opc;
        bit nxt;
        clear = 1'b1; start = 1'b0; mem_ready = 1'b0; IR_Data = '0;
        #3 check_eq("reset", obs(), 64'd0);
        @(negedge clk);
        clear = 1'b0;
        tick();
        check_eq("idle after reset", obs(), 64'd0);

        start = 1'b1; run_instr(32'h589A8000, 0, 1'b0, 1'b0);
        start = 1'b1; run_instr(32'h589A8000, 3, 1'b0, 1'b0);
        start = 1'b1; run_instr(32'h589A8000, 0, 1'b1, 1'b0);
        d1 = done_cyc;
        run_instr(32'h589A8000, 0, 1'b0, 1'b0);
        check_eq("back-to-back done gap", 64'(done_cyc - d1), 64'd6);
        start = 1'b1; run_instr(32'hF8000000, 0, 1'b0, 1'b0);
        start = 1'b1; run_instr(32'h589A8000, 0, 1'b0, 1'b1);
        start = 1'b1; run_instr(32'h589A8000, 1, 1'b0, 1'b0);
        start = 1'b1; run_instr(32'h79200000, 0, 1'b0, 1'b0);
        start = 1'b1; run_instr(32'h1A2B3C4D, 2, 1'b0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom;
            opc = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(ALU_MIN, ALU_MAX))
                                               : 5'($urandom_range(0, 31));
            waits = $urandom_range(0, 3);
            nxt = (i < 149) ? 1'($urandom_range(0, 1)) : 1'b0;
            start = 1'b1;
            run_instr({opc, r[26:0]}, waits, nxt, 1'b0);
            if (!start) begin
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    check_eq("idle gap", obs(), 64'd0);
                end
            end
        end
        start = 1'b0;
        repeat (3) tick();
        check_eq("idle at end", obs(), 64'd0);
        check_eq("done pulse count", 64'(n_done), 64'(n_ret));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
